// File: rtl/ula_seq_pkg.sv
// ula_seq_pkg: opcode constants, FSM state type and the combinational ALU shared by the ULA blocks
package ula_seq_pkg;
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_XOR = 4'b0011,
                         OP_NOR = 4'b0100, OP_SUB = 4'b0110, OP_SLTU = 4'b0111, OP_SLT = 4'b1000,
                         OP_SLL = 4'b1001, OP_SRL = 4'b1010, OP_SRA = 4'b1011;
  typedef enum logic {IDLE, SHIFT} state_t;
  function automatic logic is_shift(input logic [3:0] op);
    return op == OP_SLL || op == OP_SRL || op == OP_SRA;
  endfunction
  // {err, result}; shift codes fall into the error arm and are filtered by the caller
  function automatic logic [32:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] r;
    case (op)
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      OP_ADD:  r = {1'b0, a + b};
      OP_XOR:  r = {1'b0, a ^ b};
      OP_NOR:  r = {1'b0, ~(a | b)};
      OP_SUB:  r = {1'b0, a - b};
      OP_SLTU: r = {1'b0, 31'd0, a < b};
      OP_SLT:  r = {1'b0, 31'd0, $signed(a) < $signed(b)};
      default: r = {1'b1, 32'd0};
    endcase
    return r;
  endfunction
endpackage

// File: rtl/ula_shift_step.sv
// ula_shift_step: one-bit SLL/SRL/SRA step
module ula_shift_step
  import ula_seq_pkg::*;
(
  input  logic [31:0] d_i,
  input  logic [3:0]  op_i,
  output logic [31:0] q_o
);
  assign q_o = op_i == OP_SLL ? {d_i[30:0], 1'b0} : {op_i == OP_SRA & d_i[31], d_i[31:1]};
endmodule

// File: rtl/ula_seq.sv
// ula_seq: sequential ALU, single-cycle logic/arith ops and one-bit-per-clock shifts
module ula_seq
  import ula_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  OP,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [4:0]  Shamt,
  output logic [31:0] Result,
  output logic        Zero,
  output logic        Busy,
  output logic        Done,
  output logic        Err
);
  state_t      state_q;
  logic [31:0] sh_q, sh_d, fin_d;
  logic [3:0]  op_q, step_op;
  logic [4:0]  cnt_q;
  logic [32:0] alu;
  logic        shift_op, idle;
  assign idle     = state_q == IDLE;
  assign shift_op = is_shift(OP);
  assign step_op  = idle ? OP : op_q;
  assign alu      = alu_f(OP, A, B);
  ula_shift_step u_step (.d_i(idle ? B : sh_q), .op_i(step_op), .q_o(sh_d));
  // Value committed to Result when an operation completes on this edge
  assign fin_d = !idle ? sh_d : shift_op ? (Shamt == 5'd0 ? B : sh_d) : alu[31:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      Result  <= '0;
      Zero    <= 1'b1;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Err     <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (idle && start && shift_op && Shamt > 5'd1) begin
        state_q <= SHIFT;
        sh_q    <= sh_d;
        op_q    <= OP;
        cnt_q   <= Shamt - 5'd1;
        Busy    <= 1'b1;
      end else if ((idle && start) || (!idle && cnt_q == 5'd1)) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        Result  <= fin_d;
        Zero    <= fin_d == '0;
        Err     <= idle && !shift_op && alu[32];
        Busy    <= 1'b0;
        Done    <= 1'b1;
      end else if (!idle) begin
        sh_q  <= sh_d;
        cnt_q <= cnt_q - 5'd1;
      end
    end
  end
endmodule

// File: doc/ula_seq.md
ULA_SEQ -- requirements
Module: ula_seq

Interface
REQ-001 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request strobe, sampled only while Busy=0.
REQ-005 OP  input  4  operation code from the ALU-control decoder (AND 0000, OR 0001, ADD 0010, XOR 0011, NOR 0100, SUB 0110, SLTU 0111, SLT 1000, SLL 1001, SRL 1010, SRA 1011).
REQ-006 A  input  32  first operand, unused by shifts.
REQ-007 B  input  32  second operand; value to be shifted for SLL/SRL/SRA.
REQ-008 Shamt  input  5  shift amount, used only for shift ops.
REQ-009 Result  output  32  registered result of the last completed operation.
REQ-010 Zero  output  1  registered, high when Result==0.
REQ-011 Busy  output  1  high while a multi-cycle shift is in progress.
REQ-012 Done  output  1  one-cycle completion pulse.
REQ-013 Err  output  1  registered, high when the last completed OP was unsupported.

Function
REQ-014 FSM SHALL have two states: IDLE (Busy=0) and SHIFT (Busy=1).
REQ-015 In IDLE, start=1 SHALL capture OP, A, B, Shamt on that edge (the capture edge).
REQ-016 Non-shift ops SHALL write Result on the capture edge; Done=1 the following cycle; FSM stays IDLE.
REQ-017 Shift ops SHALL shift by one bit per edge; capture edge performs the first step with Shamt-1 steps remaining.
REQ-018 Shift with Shamt=0 SHALL complete like a non-shift op with Result=B.
REQ-019 Shift with Shamt>=2 SHALL enter SHIFT; Done SHALL be high exactly Shamt cycles after the start cycle; Busy high for Shamt-1 cycles between.
REQ-020 SRA steps SHALL replicate bit 31; SLL/SRL SHALL fill with 0.
REQ-021 ADD/SUB SHALL wrap modulo 2^32, no overflow indication.
REQ-022 SLT SHALL compare two's complement, SLTU unsigned; Result 32'd1 or 32'd0.
REQ-023 Unsupported OP (0101, 1100-1111) SHALL give Result=0, Err=1, latency 1, Done pulse.
REQ-024 Err SHALL be cleared on the next successful completion.
REQ-025 start while Busy=1 SHALL be ignored with no effect on state or outputs.
REQ-026 start in a cycle where Done=1 and Busy=0 SHALL be accepted; back-to-back non-shift ops every cycle SHALL be supported.
REQ-027 Result, Zero, Err SHALL hold between completions; Result SHALL never show intermediate shift values.

Reset
REQ-028 rst=1 SHALL force IDLE, Result=0, Zero=1, Busy=0, Done=0, Err=0, step counter=0.
REQ-029 rst SHALL dominate start in the same cycle.
REQ-030 rst during SHIFT SHALL abort the operation with no Done pulse.

Structure
REQ-031 OP code constants SHALL live in a shared include file used by this block, the ALU-control decoder and the combinational ULA.
REQ-032 One sub-module ula_shift_step (combinational single-bit SLL/SRL/SRA step) SHALL be instantiated; everything else stays in ula_seq.

Verification
REQ-033 ADD A=5 B=7 -> Result=12, Zero=0, Done one cycle after start.
REQ-034 SUB A=3 B=3 -> Result=0, Zero=1; SLT A=32'hFFFFFFFF B=1 -> 1; SLTU same operands -> 0.
REQ-035 SRA B=32'h80000000 Shamt=4 -> Result=32'hF8000000, Busy high 3 cycles, Done 4 cycles after start; start pulses during Busy ignored.
REQ-036 Three consecutive-cycle starts AND/OR/XOR A=32'hF0F0F0F0 B=32'h0F0F0F0F -> Done on 3 consecutive cycles, Results 0, 32'hFFFFFFFF, 32'hFFFFFFFF.
REQ-037 rst asserted 2 cycles into SLL Shamt=31 -> Busy=0, Result=0, Zero=1, no Done.
REQ-038 OP=4'b0101 -> Err=1, Result=0, Done pulse; following ADD 1+1 -> Err=0, Result=2.
